dmem_access_ctrl: RTL and testbench

Memory-stage data-memory access controller for the RISC-V pipeline. Sits between the EX/MEM pipeline register outputs and a multi-cycle data-memory bus with a req/ready handshake. Decodes load/store from the M-stage control fields and builds byte enables, lane-replicated write data and sign/zero-extended load data. Holds the whole pipeline (F/D/E/M registers frozen, W bubbled) until the bus transaction completes or times out.

---
 rtl/riscv_mem_pkg.sv | 40 ++++
 rtl/load_extend.sv | 27 ++
 rtl/dmem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the M-stage data-memory path: control field codes,
// the access controller state type and the alignment check.
package riscv_mem_pkg;

   localparam logic [1:0] WB_MEM = 2'b01;

   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Unlisted store/load encodings behave as word accesses.
   function automatic logic is_misaligned(input logic       is_store,
                                          input logic [1:0] store_sel,
                                          input logic [2:0] load_sel,
                                          input logic [1:0] offset);
      logic half;
      logic word;
      if (is_store) begin
         half = (store_sel == ST_SH);
         word = (store_sel == ST_SW) || (store_sel == 2'b11);
      end else begin
         half = (load_sel == LD_LH) || (load_sel == LD_LHU);
         word = !(half || (load_sel == LD_LB) || (load_sel == LD_LBU));
      end
      return (half && offset[0]) || (word && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it according to the load type.
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_sel,
   output logic [31:0] result
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      byte_val = rdata[{offset, 3'b000} +: 8];
      half_val = offset[1] ? rdata[31:16] : rdata[15:0];
      case (load_sel)
         LD_LB:   result = {{24{byte_val[7]}}, byte_val};
         LD_LH:   result = {{16{half_val[15]}}, half_val};
         LD_LBU:  result = {24'h0, byte_val};
         LD_LHU:  result = {16'h0, half_val};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access controller: issues one bus transaction per
// aligned load/store, freezes the pipeline until it completes or times out.
module dmem_access_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_enable_dmem_M,
   input  logic [1:0]       write_back_M,
   input  logic [31:0]      alu_rsl_M,
   input  logic [31:0]      wd_M,
   input  logic [1:0]       store_sel_M,
   input  logic [2:0]       load_sel_M,
   output logic             stall_M,
   output logic [31:0]      load_data_M,
   output logic             load_valid_M,
   output logic             misalign_M,
   output logic             bus_timeout,
   output logic [CNT_W-1:0] misalign_count,
   output logic             bus_req,
   output logic             bus_we,
   output logic [31:0]      bus_addr,
   output logic [31:0]      bus_wdata,
   output logic [3:0]       bus_be,
   input  logic [31:0]      bus_rdata,
   input  logic             bus_ready
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t         state;
   state_t         state_next;
   logic           is_store;
   logic           is_load;
   logic [1:0]     offset;
   logic           misaligned;
   logic           issue;
   logic           timeout_hit;
   logic [TW-1:0]  tcnt;
   logic [1:0]     offset_q;
   logic [2:0]     load_sel_q;
   logic [3:0]     be_d;
   logic [31:0]    wdata_d;
   logic [31:0]    ext_data;

   // A store takes priority when both store and load-writeback are flagged.
   assign is_store    = write_enable_dmem_M;
   assign is_load     = !write_enable_dmem_M && (write_back_M == WB_MEM);
   assign offset      = alu_rsl_M[1:0];
   assign misaligned  = is_misaligned(is_store, store_sel_M, load_sel_M, offset);
   assign misalign_M  = (state == S_IDLE) && (is_store || is_load) && misaligned;
   assign issue       = (state == S_IDLE) && (is_store || is_load) && !misaligned;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   load_extend u_load_extend (
      .rdata    (bus_rdata),
      .offset   (offset_q),
      .load_sel (load_sel_q),
      .result   (ext_data)
   );

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = 32'h0;
      if (is_store) begin
         case (store_sel_M)
            ST_SB: begin
               be_d    = 4'b0001 << offset;
               wdata_d = {4{wd_M[7:0]}};
            end
            ST_SH: begin
               be_d    = offset[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{wd_M[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = wd_M;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      stall_M    = 1'b0;
      case (state)
         S_IDLE: begin
            if (issue) begin
               stall_M    = 1'b1;
               state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            stall_M = 1'b1;
            if (bus_ready || timeout_hit) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (!rst_n) stall_M = 1'b0;
   end

   // bus_we doubles as the "this transaction is a store" flag after issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_req        <= 1'b0;
         bus_we         <= 1'b0;
         bus_addr       <= 32'h0;
         bus_wdata      <= 32'h0;
         bus_be         <= 4'h0;
         load_data_M    <= 32'h0;
         load_valid_M   <= 1'b0;
         bus_timeout    <= 1'b0;
         misalign_count <= '0;
         tcnt           <= '0;
         offset_q       <= 2'b00;
         load_sel_q     <= 3'b000;
      end else begin
         load_valid_M <= 1'b0;
         bus_timeout  <= 1'b0;
         if (misalign_M && (misalign_count != '1))
            misalign_count <= misalign_count + CNT_W'(1);
         case (state)
            S_IDLE: begin
               if (issue) begin
                  bus_req    <= 1'b1;
                  bus_we     <= is_store;
                  bus_addr   <= {alu_rsl_M[31:2], 2'b00};
                  bus_be     <= be_d;
                  bus_wdata  <= wdata_d;
                  offset_q   <= offset;
                  load_sel_q <= load_sel_M;
                  tcnt       <= '0;
               end
            end
            S_BUSY: begin
               if (bus_ready) begin
                  bus_req      <= 1'b0;
                  load_valid_M <= !bus_we;
                  load_data_M  <= bus_we ? 32'h0 : ext_data;
               end else if (timeout_hit) begin
                  bus_req      <= 1'b0;
                  load_valid_M <= !bus_we;
                  load_data_M  <= 32'h0;
                  bus_timeout  <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed table-driven bench for dmem_access_ctrl plus hand sequences for
// counter saturation, bus timeout and reset during a transaction.
module tb_dmem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        write_enable_dmem_M;
   logic [1:0]  write_back_M;
   logic [31:0] alu_rsl_M;
   logic [31:0] wd_M;
   logic [1:0]  store_sel_M;
   logic [2:0]  load_sel_M;
   logic        stall_M;
   logic [31:0] load_data_M;
   logic        load_valid_M;
   logic        misalign_M;
   logic        bus_timeout;
   logic [7:0]  misalign_count;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   int checks;
   int errors;
   int exp_count;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  wb;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  ssel;
      logic [2:0]  lsel;
      logic [31:0] rdata;
      logic        exp_mis;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[14];

   dmem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .write_enable_dmem_M (write_enable_dmem_M),
      .write_back_M        (write_back_M),
      .alu_rsl_M           (alu_rsl_M),
      .wd_M                (wd_M),
      .store_sel_M         (store_sel_M),
      .load_sel_M          (load_sel_M),
      .stall_M             (stall_M),
      .load_data_M         (load_data_M),
      .load_valid_M        (load_valid_M),
      .misalign_M          (misalign_M),
      .bus_timeout         (bus_timeout),
      .misalign_count      (misalign_count),
      .bus_req             (bus_req),
      .bus_we              (bus_we),
      .bus_addr            (bus_addr),
      .bus_wdata           (bus_wdata),
      .bus_be              (bus_be),
      .bus_rdata           (bus_rdata),
      .bus_ready           (bus_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      write_enable_dmem_M = 1'b0;
      write_back_M        = 2'b00;
      alu_rsl_M           = 32'h0;
      wd_M                = 32'h0;
      store_sel_M         = 2'b00;
      load_sel_M          = 3'b000;
      bus_ready           = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      write_enable_dmem_M = v.we;
      write_back_M        = v.wb;
      alu_rsl_M           = v.addr;
      wd_M                = v.wd;
      store_sel_M         = v.ssel;
      load_sel_M          = v.lsel;
      bus_ready           = 1'b0;
      #1;
      checkOutput({v.name, ".misalign"}, 32'(misalign_M), 32'(v.exp_mis));
      if (v.exp_mis) begin
         checkOutput({v.name, ".stall"}, 32'(stall_M), 32'd0);
         step();
         if (exp_count != 255) exp_count++;
         checkOutput({v.name, ".count"}, 32'(misalign_count), 32'(exp_count));
         checkOutput({v.name, ".req"}, 32'(bus_req), 32'd0);
      end else begin
         checkOutput({v.name, ".stall_detect"}, 32'(stall_M), 32'd1);
         step();
         checkOutput({v.name, ".req"}, 32'(bus_req), 32'd1);
         checkOutput({v.name, ".stall_busy"}, 32'(stall_M), 32'd1);
         checkOutput({v.name, ".we"}, 32'(bus_we), 32'(v.exp_we));
         checkOutput({v.name, ".addr"}, bus_addr, {v.addr[31:2], 2'b00});
         if (v.exp_we) begin
            checkOutput({v.name, ".be"}, 32'(bus_be), 32'(v.exp_be));
            checkOutput({v.name, ".wdata"}, bus_wdata, v.exp_wdata);
         end
         bus_ready = 1'b1;
         bus_rdata = v.rdata;
         step();
         bus_ready = 1'b0;
         bus_rdata = 32'h5A5A_5A5A;
         checkOutput({v.name, ".req_done"}, 32'(bus_req), 32'd0);
         checkOutput({v.name, ".stall_done"}, 32'(stall_M), 32'd0);
         checkOutput({v.name, ".valid"}, 32'(load_valid_M), 32'(v.exp_valid));
         checkOutput({v.name, ".data"}, load_data_M, v.exp_data);
         step();
         checkOutput({v.name, ".valid_drop"}, 32'(load_valid_M), 32'd0);
      end
      clearInputs();
   endtask

   initial begin
      vec_t v;
      int bad;
      checks    = 0;
      errors    = 0;
      exp_count = 0;
      bus_rdata = 32'h0;

      //            name          we    wb     addr          wd            ssel   lsel    rdata         mis   we    be       wdata         valid data
      vecs[0]  = '{"lw_100",    1'b0, 2'b01, 32'h0000_0100, 32'h0,        2'b00, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'hDEAD_BEEF};
      vecs[1]  = '{"lb_103",    1'b0, 2'b01, 32'h0000_0103, 32'h0,        2'b00, 3'b000, 32'h80FF_0000, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'hFFFF_FF80};
      vecs[2]  = '{"lbu_103",   1'b0, 2'b01, 32'h0000_0103, 32'h0,        2'b00, 3'b011, 32'h80FF_0000, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'h0000_0080};
      vecs[3]  = '{"lh_102",    1'b0, 2'b01, 32'h0000_0102, 32'h0,        2'b00, 3'b001, 32'h80FF_0000, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'hFFFF_80FF};
      vecs[4]  = '{"lhu_102",   1'b0, 2'b01, 32'h0000_0102, 32'h0,        2'b00, 3'b100, 32'h80FF_0000, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'h0000_80FF};
      vecs[5]  = '{"lb_101",    1'b0, 2'b01, 32'h0000_0101, 32'h0,        2'b00, 3'b000, 32'h1234_5678, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'h0000_0056};
      vecs[6]  = '{"sh_202",    1'b1, 2'b00, 32'h0000_0202, 32'h1234_ABCD, 2'b01, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0};
      vecs[7]  = '{"sb_201",    1'b1, 2'b00, 32'h0000_0201, 32'h0000_00A5, 2'b00, 3'b000, 32'h0,        1'b0, 1'b1, 4'h2, 32'hA5A5_A5A5, 1'b0, 32'h0};
      vecs[8]  = '{"sw11_204",  1'b1, 2'b00, 32'h0000_0204, 32'hCAFE_F00D, 2'b11, 3'b000, 32'h0,        1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[9]  = '{"sw_301",    1'b1, 2'b00, 32'h0000_0301, 32'h1111_1111, 2'b10, 3'b000, 32'h0,        1'b1, 1'b0, 4'h0,   32'h0,        1'b0, 32'h0};
      vecs[10] = '{"lh_105",    1'b0, 2'b01, 32'h0000_0105, 32'h0,        2'b00, 3'b001, 32'h0,        1'b1, 1'b0, 4'h0,   32'h0,        1'b0, 32'h0};
      vecs[11] = '{"lw_102",    1'b0, 2'b01, 32'h0000_0102, 32'h0,        2'b00, 3'b010, 32'h0,        1'b1, 1'b0, 4'h0,   32'h0,        1'b0, 32'h0};
      vecs[12] = '{"sb_ld_203", 1'b1, 2'b01, 32'h0000_0203, 32'h0000_007F, 2'b00, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'h8, 32'h7F7F_7F7F, 1'b0, 32'h0};
      vecs[13] = '{"lw111_108", 1'b0, 2'b01, 32'h0000_0108, 32'h0,        2'b00, 3'b111, 32'h0BAD_F00D, 1'b0, 1'b0, 4'h0,   32'h0,        1'b1, 32'h0BAD_F00D};

      // Reset with a load presented: stall must stay low, registers cleared.
      clearInputs();
      rst_n        = 1'b0;
      write_back_M = 2'b01;
      load_sel_M   = 3'b010;
      alu_rsl_M    = 32'h0000_0100;
      step();
      step();
      checkOutput("rst.stall", 32'(stall_M), 32'd0);
      checkOutput("rst.req", 32'(bus_req), 32'd0);
      checkOutput("rst.valid", 32'(load_valid_M), 32'd0);
      checkOutput("rst.data", load_data_M, 32'd0);
      checkOutput("rst.count", 32'(misalign_count), 32'd0);
      checkOutput("rst.timeout", 32'(bus_timeout), 32'd0);
      checkOutput("rst.be", 32'(bus_be), 32'd0);
      clearInputs();
      rst_n = 1'b1;
      step();

      // bus_ready while idle must not start or complete anything.
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;
      checkOutput("idle_ready.req", 32'(bus_req), 32'd0);
      checkOutput("idle_ready.valid", 32'(load_valid_M), 32'd0);

      for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

      // Hold a misaligned store for 300 cycles: counter saturates at 255.
      write_enable_dmem_M = 1'b1;
      store_sel_M         = 2'b10;
      alu_rsl_M           = 32'h0000_0301;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (!misalign_M || stall_M) bad++;
         step();
         if (exp_count != 255) exp_count++;
         if (bus_req) bad++;
      end
      checkOutput("sat.no_bus", 32'(bad), 32'd0);
      checkOutput("sat.count", 32'(misalign_count), 32'(exp_count));
      checkOutput("sat.count255", 32'(misalign_count), 32'd255);
      clearInputs();
      step();

      // Load with no bus_ready: aborts after 16 BUSY cycles.
      write_back_M = 2'b01;
      load_sel_M   = 3'b010;
      alu_rsl_M    = 32'h0000_0400;
      step();
      bad = 0;
      for (int i = 1; i <= 16; i++) begin
         if (!stall_M || !bus_req || bus_timeout) bad++;
         if (i < 16) step();
      end
      checkOutput("tmo.busy16", 32'(bad), 32'd0);
      step();
      checkOutput("tmo.pulse", 32'(bus_timeout), 32'd1);
      checkOutput("tmo.data", load_data_M, 32'd0);
      checkOutput("tmo.stall", 32'(stall_M), 32'd0);
      checkOutput("tmo.req", 32'(bus_req), 32'd0);
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;
      checkOutput("tmo.pulse_drop", 32'(bus_timeout), 32'd0);
      checkOutput("tmo.req_idle", 32'(bus_req), 32'd0);
      clearInputs();
      step();

      // Reset while BUSY abandons the access; a later load must still work.
      write_back_M = 2'b01;
      load_sel_M   = 3'b010;
      alu_rsl_M    = 32'h0000_0500;
      step();
      checkOutput("rstbusy.req_before", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstbusy.stall_comb", 32'(stall_M), 32'd0);
      step();
      checkOutput("rstbusy.req", 32'(bus_req), 32'd0);
      checkOutput("rstbusy.stall", 32'(stall_M), 32'd0);
      checkOutput("rstbusy.count", 32'(misalign_count), 32'd0);
      exp_count = 0;
      clearInputs();
      rst_n = 1'b1;
      step();
      v = '{"lw_after_rst", 1'b0, 2'b01, 32'h0000_0600, 32'h0, 2'b00, 3'b010, 32'h1357_9BDF,
            1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1357_9BDF};
      applyStimulus(v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
